// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake with imem,
// holds the fetched word for the decoder and steps the PC when the instruction retires.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instrValid,
  input  logic        retire,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] fetchCount,
  output logic [1:0]  fetchState
);

  // Handshake: imemReq stays high and imemAddr stays stable from the first FETCH
  // cycle until the cycle imemAck=1 is sampled; one ack transfers one word.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign imemAddr   = pc;
  assign opcode     = instr[31:26];
  assign pcPlus4    = pc + 32'd4;
  assign fetchState = state;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Jump wins over a taken branch when the decoder raises both.
  always_comb begin
    next_pc = pcPlus4;
    if (jump)
      next_pc = {pcPlus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pcPlus4 + branch_off;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      pc         <= RESET_PC & ~32'd3;
      instr      <= 32'd0;
      instrValid <= 1'b0;
      imemReq    <= 1'b0;
      fetchCount <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          imemReq <= 1'b1;
        end
        FETCH: begin
          if (imemAck) begin
            instr      <= imemData;
            instrValid <= 1'b1;
            imemReq    <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            pc         <= next_pc;
            instrValid <= 1'b0;
            fetchCount <= fetchCount + 32'd1;
            imemReq    <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state   <= IDLE;
          imemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
